program_loader: RTL and testbench

Boot-time loader that sits directly upstream of the single-cycle processor and its instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into instruction memory and verifies an XOR checksum. Only after a verified load does it raise the processor's start input.

---
 rtl/program_loader.sv | 150 +++++++++++++++
 tb/tb_program_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time loader placed in front of the single-cycle processor and its
// instruction memory. It takes a program as a byte stream and builds
// little-endian 32-bit words from it. Each word is written into
// instruction memory, and the loader checks an XOR checksum over all data
// bytes. The processor's start input goes high only after the load has
// been verified.
//
// Stream format: LEN[15:8], LEN[7:0], 4*LEN data bytes (each word LSB
// first), then one checksum byte (XOR of all data bytes).
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   byte_in    - incoming stream byte
//   byte_valid - byte_in valid this cycle
//   byte_ready - loader accepts a byte (transfer = byte_valid && byte_ready)
//   im_we      - instruction-memory write strobe, one cycle per word
//   im_addr    - instruction-memory byte address (word aligned)
//   im_wdata   - instruction word being written
//   start      - processor start, held high after a verified load
//   busy       - length accepted, load not yet verified or failed
//   done       - load verified (held)
//   error      - load rejected (held until reset)
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Word counter must be able to reach MAX_WORDS without wrapping
  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam logic [15:0]       MAX_LEN = 16'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] LEN_HI = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] CHK    = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;

  logic [2:0]      state;
  logic            ready_en;
  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [1:0]      byte_cnt;
  logic [WC_W-1:0] word_cnt;
  logic [23:0]     word_buf;
  logic [7:0]      csum;

  logic        xfer;
  logic [15:0] new_len;

  // ready_en keeps byte_ready low until the first clock after reset release
  assign byte_ready = ready_en &&
                      (state == LEN_HI || state == LEN_LO ||
                       state == DATA   || state == CHK);
  assign busy  = (state == DATA) || (state == CHK);
  assign done  = (state == RUN);
  assign start = (state == RUN);
  assign error = (state == ERR);

  assign xfer    = byte_valid && byte_ready;
  assign new_len = {len_hi, byte_in};

  // Stream parser and word assembler. The 4th byte of the last word moves
  // the FSM straight to CHK, so a checksum byte that arrives during that
  // word's write cycle is already treated as the checksum. The write strobe
  // and the word counter are handled apart from the state so the pulse
  // finishes no matter which state follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LEN_HI;
      ready_en <= 1'b0;
      len_hi   <= 8'h00;
      len      <= 16'h0000;
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      word_buf <= 24'h000000;
      csum     <= 8'h00;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= 32'h0000_0000;
    end else begin
      ready_en <= 1'b1;

      if (im_we) begin
        im_we    <= 1'b0;
        word_cnt <= word_cnt + 1'b1;
      end

      case (state)
        LEN_HI: begin
          if (xfer) begin
            len_hi <= byte_in;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len <= new_len;
            if (new_len == 16'h0000 || new_len > MAX_LEN) state <= ERR;
            else                                         state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            csum     <= csum ^ byte_in;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= byte_in;
              2'd1: word_buf[15:8]  <= byte_in;
              2'd2: word_buf[23:16] <= byte_in;
              default: begin
                im_we    <= 1'b1;
                im_wdata <= {byte_in, word_buf};
                im_addr  <= BASE + ADDR_W'({word_cnt, 2'b00});
                if (16'(word_cnt) == len - 16'd1) state <= CHK;
              end
            endcase
          end
        end
        CHK: begin
          if (xfer) state <= (byte_in == csum) ? RUN : ERR;
        end
        RUN, ERR: begin
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Directed sequence of loads driven into program_loader. The bench builds
// each byte stream, works out the memory writes and final status from the
// stream format directly, and compares them with what the loader produces.
// ---------------------------------------------------------------------------
module tb_program_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 256;
  localparam int BASE_ADDR = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              start;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic        exp_ok;
  logic        exp_err;
  int          exp_accept;
  int          we_count = 0;

  program_loader #(
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(MAX_WORDS),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Record every instruction-memory write seen on the falling edge
  always @(negedge clk) begin
    if (rst && im_we) begin
      got_addr.push_back(32'(im_addr));
      got_data.push_back(im_wdata);
      we_count++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected writes and outcome, taken straight from the stream format
  task automatic build_expected();
    int len;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    x = 8'h00;
    len = int'(stream[0]) * 256 + int'(stream[1]);
    if (len == 0 || len > MAX_WORDS) begin
      exp_err    = 1'b1;
      exp_ok     = 1'b0;
      exp_accept = 2;
    end else begin
      for (int w = 0; w < len; w++) begin
        int b;
        b = 2 + 4 * w;
        exp_addr.push_back(32'(BASE_ADDR + 4 * w));
        exp_data.push_back(32'(stream[b]) + (32'(stream[b+1]) << 8) +
                           (32'(stream[b+2]) << 16) + (32'(stream[b+3]) << 24));
        x = x ^ stream[b] ^ stream[b+1] ^ stream[b+2] ^ stream[b+3];
      end
      exp_ok     = (x == stream[2 + 4 * len]);
      exp_err    = !exp_ok;
      exp_accept = 3 + 4 * len;
    end
  endtask

  task automatic make_random(input int len, input bit bad_sum);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    stream.delete();
    stream.push_back(8'(len >> 8));
    stream.push_back(8'(len));
    if (len >= 1 && len <= MAX_WORDS) begin
      for (int i = 0; i < 4 * len; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        x = x ^ b;
      end
      stream.push_back(bad_sum ? (x ^ 8'h01) : x);
    end
  endtask

  task automatic make_test1(input logic [7:0] sum);
    stream = '{8'h00, 8'h02, 8'h05, 8'h10, 8'hA0, 8'hE3,
               8'h01, 8'h10, 8'h81, 8'hE2};
    stream.push_back(sum);
  endtask

  // Send stream bytes [first, last) with random idle gaps of 0..gap_max
  task automatic apply_stimulus(input int first, input int last, input int gap_max);
    for (int i = first; i < last; i++) begin
      int n;
      int gap;
      byte_valid = 1'b0;
      gap = int'($urandom_range(0, gap_max));
      repeat (gap) begin
        byte_in = 8'($urandom);
        @(negedge clk);
      end
      byte_in    = stream[i];
      byte_valid = 1'b1;
      n = 0;
      while (!byte_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!byte_ready) begin
        check_output("ready_timeout", 32'(byte_ready), 32'd1);
        byte_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (i == 1) begin
        check_output("busy_after_len", 32'(busy), 32'(exp_accept > 2));
        check_output("error_after_len", 32'(error), 32'(exp_accept == 2));
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int gap_max);
    int n;
    build_expected();
    got_addr.delete();
    got_data.delete();
    apply_stimulus(0, exp_accept, gap_max);
    check_output({tag, "_start"}, 32'(start), 32'(exp_ok));
    check_output({tag, "_done"}, 32'(done), 32'(exp_ok));
    check_output({tag, "_error"}, 32'(error), 32'(exp_err));
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_ready"}, 32'(byte_ready), 32'd0);
    repeat (5) @(negedge clk);
    check_output({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_output({tag, "_addr"}, got_addr[i], exp_addr[i]);
      check_output({tag, "_data"}, got_data[i], exp_data[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check_output({tag, "_we"}, 32'(im_we), 32'd0);
    check_output({tag, "_addr"}, 32'(im_addr), 32'd0);
    check_output({tag, "_wdata"}, im_wdata, 32'd0);
    check_output({tag, "_start"}, 32'(start), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("ready_before_clock", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    check_output("ready_after_clock", 32'(byte_ready), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    byte_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    release_reset();
  endtask

  initial begin
    int base;
    $display("[TB] program_loader bench starting");
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("por");
    release_reset();

    // Good two-word load
    make_test1(8'h24);
    run_and_check("t1", 0);

    // Extra bytes while running are ignored
    base = we_count;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      #1;
      check_output("run_start", 32'(start), 32'd1);
      check_output("run_done", 32'(done), 32'd1);
      check_output("run_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_output("run_no_writes", 32'(we_count - base), 32'd0);

    // Bad checksum, gaps between bytes
    do_reset("rst2");
    make_test1(8'h25);
    run_and_check("t2", 2);

    // Zero length
    do_reset("rst3");
    make_random(0, 1'b0);
    run_and_check("t3", 1);

    // Reset in the middle of a load, including a write pulse in flight
    do_reset("rst5a");
    make_test1(8'h24);
    build_expected();
    apply_stimulus(0, 6, 0);
    check_output("t5_we_pulse", 32'(im_we), 32'd1);
    check_output("t5_wdata", im_wdata, exp_data[0]);
    apply_stimulus(6, 8, 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("t5_abort");
    release_reset();
    run_and_check("t5_replay", 0);

    // Full-size load with random data and gaps
    do_reset("rst4a");
    make_random(MAX_WORDS, 1'b0);
    run_and_check("t4_max", 5);

    // One word too many
    do_reset("rst4b");
    make_random(MAX_WORDS + 1, 1'b0);
    run_and_check("t4_over", 3);

    // Random small loads, some with a corrupted checksum
    for (int k = 0; k < 4; k++) begin
      do_reset("rstr");
      make_random(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      run_and_check("rand", 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
